// File: rtl/duck_motion_ctrl_if.sv
// Bus bundle between the game-logic stage and its neighbours: the video-bus tap, the start/hit
// pulses, and the per-frame sprite position and status outputs.
`timescale 1ns/1ps
interface duck_motion_ctrl_if;
  logic [38:0] video_bus_in;
  logic        start;
  logic        hit;
  logic [10:0] xpos;
  logic [9:0]  ypos;
  logic [2:0]  sprite_id;
  logic        active;
  logic        shot_done;
  logic        escaped;

  modport master (
    output video_bus_in, start, hit,
    input  xpos, ypos, sprite_id, active, shot_done, escaped
  );

  modport slave (
    input  video_bus_in, start, hit,
    output xpos, ypos, sprite_id, active, shot_done, escaped
  );
endinterface

// File: rtl/duck_motion_ctrl.sv
// Per-duck life-cycle FSM (idle, fly, hit, fall, escape) that updates position and sprite once per frame.
// Optional macro DUCK_LFSR_EN: pseudo-random spawn x and horizontal direction from a 16-bit LFSR.
`timescale 1ns/1ps
module duck_motion_ctrl #(
  parameter int X_MAX      = 511,
  parameter int Y_MAX      = 351,
  parameter int START_X    = 100,
  parameter int START_Y    = 351,
  parameter int SPEED      = 2,
  parameter int FALL_SPEED = 4,
  parameter int ANIM_DIV   = 6,
  parameter int HIT_FRAMES = 30,
  parameter int FLY_FRAMES = 600,
  parameter int VSYNC_BIT  = 0
) (
  input  logic aclk,
  input  logic aresetn,
  duck_motion_ctrl_if.slave bus
);

  localparam int AW = $clog2(ANIM_DIV);
  localparam int HW = $clog2(HIT_FRAMES);
  localparam int FW = $clog2(FLY_FRAMES);

  localparam logic signed [11:0] XMAX  = 12'(X_MAX);
  localparam logic signed [11:0] YMAX  = 12'(Y_MAX);
  localparam logic signed [11:0] SPD   = 12'(SPEED);
  localparam logic signed [11:0] FSPD  = 12'(FALL_SPEED);
  localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
  localparam logic [HW-1:0] HIT_LAST   = HW'(HIT_FRAMES - 1);
  localparam logic [FW-1:0] FLY_LAST   = FW'(FLY_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, FLY, HIT, FALL, ESCAPE} state_t;

  state_t                state_reg;
  logic signed [11:0]    x_reg, y_reg;
  logic                  dx_pos_reg, dy_pos_reg;
  logic [AW-1:0]         anim_cnt_reg;
  logic [HW-1:0]         hit_cnt_reg;
  logic [FW-1:0]         fly_cnt_reg;
  logic [2:0]            sprite_reg;
  logic                  active_reg, shot_done_reg, escaped_reg;
  logic                  vsync_prev_reg, start_flag_reg, hit_flag_reg;

  logic                  vsync, frame_tick, start_pend, hit_pend;
  logic signed [11:0]    sum_x, sum_y, fly_x, fly_y, fall_y, esc_y, spawn_x;
  logic                  fly_dx, fly_dy, anim_wrap, spawn_dx;
  logic [AW-1:0]         anim_next;
  logic [2:0]            sprite_anim;
  logic                  unused_bus_bits;

  assign vsync           = bus.video_bus_in[VSYNC_BIT];
  assign unused_bus_bits = ^bus.video_bus_in;
  assign frame_tick      = vsync & ~vsync_prev_reg;
  // A pulse arriving on the tick cycle itself is honoured on that tick.
  assign start_pend      = start_flag_reg | bus.start;
  assign hit_pend        = hit_flag_reg | bus.hit;

  always_comb begin
    sum_x = x_reg + (dx_pos_reg ? SPD : -SPD);
    sum_y = y_reg + (dy_pos_reg ? SPD : -SPD);
    fly_x = sum_x;
    fly_dx = dx_pos_reg;
    if (sum_x < 0) begin
      fly_x  = '0;
      fly_dx = 1'b1;
    end else if (sum_x > XMAX) begin
      fly_x  = XMAX;
      fly_dx = 1'b0;
    end
    fly_y = sum_y;
    fly_dy = dy_pos_reg;
    if (sum_y < 0) begin
      fly_y  = '0;
      fly_dy = 1'b1;
    end else if (sum_y > YMAX) begin
      fly_y  = YMAX;
      fly_dy = 1'b0;
    end
    anim_wrap   = (anim_cnt_reg == ANIM_LAST);
    anim_next   = anim_wrap ? '0 : anim_cnt_reg + AW'(1);
    sprite_anim = sprite_reg;
    if (anim_wrap) sprite_anim = (sprite_reg == 3'd2) ? 3'd0 : sprite_reg + 3'd1;
    fall_y = y_reg + FSPD;
    esc_y  = y_reg - SPD;
  end

`ifdef DUCK_LFSR_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_reg <= 16'hACE1;
    else          lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  always_comb begin
    spawn_x  = {3'b000, lfsr_reg[8:0]};
    if (spawn_x > XMAX) spawn_x = XMAX;
    spawn_dx = lfsr_reg[9];
  end
`else
  assign spawn_x  = 12'(START_X);
  assign spawn_dx = 1'b1;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      x_reg          <= 12'(START_X);
      y_reg          <= 12'(START_Y);
      dx_pos_reg     <= 1'b1;
      dy_pos_reg     <= 1'b0;
      anim_cnt_reg   <= '0;
      hit_cnt_reg    <= '0;
      fly_cnt_reg    <= '0;
      sprite_reg     <= 3'd0;
      active_reg     <= 1'b0;
      shot_done_reg  <= 1'b0;
      escaped_reg    <= 1'b0;
      vsync_prev_reg <= 1'b0;
      start_flag_reg <= 1'b0;
      hit_flag_reg   <= 1'b0;
    end else begin
      vsync_prev_reg <= vsync;
      shot_done_reg  <= 1'b0;
      escaped_reg    <= 1'b0;
      if (!frame_tick) begin
        start_flag_reg <= start_pend;
        hit_flag_reg   <= hit_pend;
      end else begin
        // Every pending request is either consumed or dropped on the tick.
        start_flag_reg <= 1'b0;
        hit_flag_reg   <= 1'b0;
        case (state_reg)
          IDLE: begin
            if (start_pend) begin
              state_reg    <= FLY;
              active_reg   <= 1'b1;
              x_reg        <= spawn_x;
              y_reg        <= 12'(START_Y);
              dx_pos_reg   <= spawn_dx;
              dy_pos_reg   <= 1'b0;
              anim_cnt_reg <= '0;
              hit_cnt_reg  <= '0;
              fly_cnt_reg  <= '0;
              sprite_reg   <= 3'd0;
            end
          end
          FLY: begin
            // The duck freezes where it was drawn when it was shot.
            if (hit_pend) begin
              state_reg   <= HIT;
              sprite_reg  <= 3'd3;
              hit_cnt_reg <= '0;
            end else begin
              x_reg        <= fly_x;
              y_reg        <= fly_y;
              dx_pos_reg   <= fly_dx;
              dy_pos_reg   <= fly_dy;
              anim_cnt_reg <= anim_next;
              sprite_reg   <= sprite_anim;
              fly_cnt_reg  <= fly_cnt_reg + FW'(1);
              if (fly_cnt_reg == FLY_LAST) state_reg <= ESCAPE;
            end
          end
          HIT: begin
            if (hit_cnt_reg == HIT_LAST) begin
              state_reg  <= FALL;
              sprite_reg <= 3'd4;
            end else begin
              hit_cnt_reg <= hit_cnt_reg + HW'(1);
            end
          end
          FALL: begin
            if (fall_y >= YMAX) begin
              y_reg         <= YMAX;
              shot_done_reg <= 1'b1;
              state_reg     <= IDLE;
              active_reg    <= 1'b0;
              sprite_reg    <= 3'd0;
            end else begin
              y_reg <= fall_y;
            end
          end
          ESCAPE: begin
            anim_cnt_reg <= anim_next;
            sprite_reg   <= sprite_anim;
            if (esc_y < 0) begin
              y_reg       <= '0;
              escaped_reg <= 1'b1;
              state_reg   <= IDLE;
              active_reg  <= 1'b0;
              sprite_reg  <= 3'd0;
            end else begin
              y_reg <= esc_y;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.xpos      = x_reg[10:0];
  assign bus.ypos      = y_reg[9:0];
  assign bus.sprite_id = sprite_reg;
  assign bus.active    = active_reg;
  assign bus.shot_done = shot_done_reg;
  assign bus.escaped   = escaped_reg;

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Scoreboard bench for duck_motion_ctrl: stimulus queues per-frame expectations, a monitor
// counts frame ticks and pulse outputs and compares when the tagged frame's outputs appear.
`timescale 1ns/1ps
module tb_duck_motion_ctrl;
  localparam int VB = 0;

  typedef struct {
    int    tag;
    string name;
    int    x, y, spr;
    bit    chk_spr;
    int    act, shots, escs;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  duck_motion_ctrl_if bus ();

  duck_motion_ctrl #(.VSYNC_BIT(VB)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  exp_t exp_q[$];
  exp_t rst_q[$];
  int   errors = 0, checks = 0;
  int   stim_frame = 0, mon_frame = 0, shot_cnt = 0, esc_cnt = 0;
  bit   stim_done = 1'b0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_at(int ahead, string name, int x, int y, int spr, bit cs, int act, int shots, int escs);
    exp_t e;
    e.tag = stim_frame + ahead; e.name = name; e.x = x; e.y = y; e.spr = spr;
    e.chk_spr = cs; e.act = act; e.shots = shots; e.escs = escs;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(int cycles);
    exp_t e;
    e.tag = 0; e.name = "reset"; e.x = 100; e.y = 351; e.spr = 0;
    e.chk_spr = 1'b1; e.act = 0; e.shots = 0; e.escs = 0;
    rst_q.push_back(e);
    aresetn = 1'b0;
    repeat (cycles) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic drive_vsync(bit v);
    logic [38:0] vb;
    vb = 39'({$urandom, $urandom});
    vb[VB] = v;
    bus.video_bus_in = vb;
  endtask

  task automatic run_frames(int n);
    repeat (n) begin
      @(posedge aclk); #1 drive_vsync(1'b1);
      stim_frame++;
      repeat (2) @(posedge aclk);
      #1 drive_vsync(1'b0);
      repeat (2) @(posedge aclk);
    end
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1 bus.start = 1'b1;
    @(posedge aclk); #1 bus.start = 1'b0;
  endtask

  task automatic pulse_hit();
    @(posedge aclk); #1 bus.hit = 1'b1;
    @(posedge aclk); #1 bus.hit = 1'b0;
  endtask

  // Monitor: a vsync rise seen at one falling edge means the DUT ticks at the next rising edge,
  // so that frame's outputs are sampled at the falling edge after it.
  initial begin
    bit   pending = 1'b0;
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pending = 1'b0;
        prev = 1'b0;
        if (rst_q.size() > 0) begin
          e = rst_q.pop_front();
          check("reset.x", int'(bus.xpos), e.x);
          check("reset.y", int'(bus.ypos), e.y);
          check("reset.spr", int'(bus.sprite_id), e.spr);
          check("reset.act", int'(bus.active), e.act);
          check("reset.shot_done", int'(bus.shot_done), 0);
          check("reset.escaped", int'(bus.escaped), 0);
          $display("reset check x=%0d y=%0d spr=%0d act=%0d", bus.xpos, bus.ypos, bus.sprite_id, bus.active);
        end
      end else begin
        if (bus.shot_done) shot_cnt++;
        if (bus.escaped) esc_cnt++;
        if (pending) begin
          mon_frame++;
          pending = 1'b0;
          if (exp_q.size() > 0 && exp_q[0].tag <= mon_frame) begin
            e = exp_q.pop_front();
            check({e.name, ".frame"}, mon_frame, e.tag);
            check({e.name, ".x"}, int'(bus.xpos), e.x);
            check({e.name, ".y"}, int'(bus.ypos), e.y);
            if (e.chk_spr) check({e.name, ".spr"}, int'(bus.sprite_id), e.spr);
            check({e.name, ".act"}, int'(bus.active), e.act);
            check({e.name, ".shots"}, shot_cnt, e.shots);
            check({e.name, ".escs"}, esc_cnt, e.escs);
            $display("frame %0d %s x=%0d y=%0d spr=%0d act=%0d shots=%0d escs=%0d",
                     mon_frame, e.name, bus.xpos, bus.ypos, bus.sprite_id, bus.active, shot_cnt, esc_cnt);
          end
        end
        if (bus.video_bus_in[VB] && !prev) pending = 1'b1;
        prev = bus.video_bus_in[VB];
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.hit = 1'b0;
    bus.video_bus_in = '0;
    apply_reset(3);

    // Idle, then first duck: 12 frames of flight from the spawn point
    expect_at(3, "idle", 100, 351, 0, 1, 0, 0, 0);
    run_frames(3);
    pulse_start();
    expect_at(1, "spawn", 100, 351, 0, 1, 1, 0, 0);
    expect_at(6, "fly5", 110, 341, 0, 1, 1, 0, 0);
    expect_at(7, "fly6", 112, 339, 1, 1, 1, 0, 0);
    expect_at(12, "fly11", 122, 329, 1, 1, 1, 0, 0);
    expect_at(13, "fly12", 124, 327, 2, 1, 1, 0, 0);
    run_frames(13);
    pulse_start();
    expect_at(1, "start_busy", 126, 325, 2, 1, 1, 0, 0);
    run_frames(1);

    // Shot: hold 30 frames, fall 4 px/frame, land once
    pulse_hit();
    expect_at(1, "hit", 126, 325, 3, 1, 1, 0, 0);
    expect_at(30, "hit_hold", 126, 325, 3, 1, 1, 0, 0);
    expect_at(31, "fall_enter", 126, 325, 4, 1, 1, 0, 0);
    expect_at(32, "fall1", 126, 329, 4, 1, 1, 0, 0);
    expect_at(37, "fall6", 126, 349, 4, 1, 1, 0, 0);
    expect_at(38, "ground", 126, 351, 0, 0, 0, 1, 0);
    expect_at(40, "idle_after", 126, 351, 0, 0, 0, 1, 0);
    run_frames(40);
    pulse_hit();
    expect_at(1, "idle_hit", 126, 351, 0, 0, 0, 1, 0);
    run_frames(1);

    // Reset while falling: no landing pulse afterwards
    pulse_start();
    expect_at(1, "spawn2", 100, 351, 0, 1, 1, 1, 0);
    expect_at(6, "fly2_5", 110, 341, 0, 1, 1, 1, 0);
    run_frames(6);
    pulse_hit();
    expect_at(1, "hit2", 110, 341, 3, 1, 1, 1, 0);
    expect_at(31, "fall2_enter", 110, 341, 4, 1, 1, 1, 0);
    expect_at(33, "fall2_2", 110, 349, 4, 1, 1, 1, 0);
    run_frames(33);
    @(posedge aclk);
    #1 apply_reset(3);
    expect_at(10, "post_reset", 100, 351, 0, 1, 0, 1, 0);
    run_frames(10);

    // Full flight: wall bounces, timeout into escape, escape at the top
    pulse_start();
    expect_at(1, "spawn3", 100, 351, 0, 1, 1, 1, 0);
    expect_at(207, "xwall", 511, 60, 1, 1, 1, 1, 0);
    expect_at(208, "xwall_back", 509, 62, 1, 1, 1, 1, 0);
    expect_at(353, "yfloor", 219, 351, 1, 1, 1, 1, 0);
    expect_at(463, "xzero", 0, 131, 2, 1, 1, 1, 0);
    expect_at(464, "xzero_back", 2, 129, 2, 1, 1, 1, 0);
    expect_at(600, "fly599", 274, 142, 0, 1, 1, 1, 0);
    expect_at(601, "escape_enter", 276, 144, 1, 1, 1, 1, 0);
    expect_at(673, "escape_top", 276, 0, 1, 1, 1, 1, 0);
    expect_at(674, "escaped", 276, 0, 0, 0, 0, 1, 1);
    run_frames(674);

    // Hit on the same tick as the timeout: shot wins
    pulse_start();
    expect_at(1, "spawn4", 100, 351, 0, 1, 1, 1, 1);
    expect_at(600, "fly599b", 274, 142, 0, 1, 1, 1, 1);
    run_frames(600);
    pulse_hit();
    expect_at(1, "hit_timeout", 274, 142, 3, 1, 1, 1, 1);
    expect_at(31, "fall4_enter", 274, 142, 4, 1, 1, 1, 1);
    expect_at(83, "fall4_last", 274, 350, 4, 1, 1, 1, 1);
    expect_at(84, "ground4", 274, 351, 0, 0, 0, 2, 1);
    expect_at(90, "final", 274, 351, 0, 0, 0, 2, 1);
    run_frames(90);

    repeat (10) @(posedge aclk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".never_seen"}, mon_frame, e.tag);
    end
    check("reset_queue_drained", rst_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/duck_motion_ctrl.md
Name: duck_motion_ctrl

Overview:
Per-duck game-logic stage that sits directly upstream of the duck sprite drawer. It taps the video bus to detect frame starts and runs the duck life-cycle state machine (fly, hit, fall, escape). Each frame it updates the duck position and the sprite_id that the sprite drawer consumes. Position, sprite and status only change once per frame, so the drawn image never tears mid-frame.

Parameters:
X_MAX, 511, rightmost legal sprite x (top-left corner), pixels
Y_MAX, 351, lowest legal flight y; also the ground line for falling
START_X, 100, spawn x when DUCK_LFSR_EN is off
START_Y, 351, spawn y
SPEED, 2, flight pixels per frame on each axis
FALL_SPEED, 4, fall pixels per frame
ANIM_DIV, 6, frames per flap-animation step
HIT_FRAMES, 30, frames held in HIT
FLY_FRAMES, 600, frames before the duck escapes

Ports:
aclk  in  1  pixel clock
aresetn  in  1  asynchronous active-low reset
video_bus_in  in  39  video bus; only the vsync field (per video_bus.h) is used
start  in  1  one-cycle pulse: spawn a duck
hit  in  1  one-cycle pulse from shot detection: duck was shot
xpos  out  11  sprite x
ypos  out  10  sprite y
sprite_id  out  3  sprite index for the drawer
active  out  1  duck is visible (state != IDLE)
shot_done  out  1  one-cycle pulse: duck reached the ground
escaped  out  1  one-cycle pulse: duck left the top of the screen

Behaviour:
- Reset (async, aresetn=0): state=IDLE, xpos=START_X, ypos=START_Y, sprite_id=0, active=0, shot_done=0, escaped=0, all counters and latches 0, dx=+1, dy=-1.
- frame_tick: one-cycle pulse on the rising edge of vsync, detected with a registered previous-vsync bit. All motion, animation and state changes happen only on frame_tick cycles.
- hit and start are single-cycle inputs latched into sticky flags. The flags clear when consumed on the next frame_tick or when ignored, so a pulse between ticks is never lost.
- IDLE:
  - On a start pulse: load spawn position, dx, dy=-1 and clear counters; move to FLY at the next frame_tick.
  - hit is ignored.
- FLY:
  - Each tick: x += dx*SPEED and y += dy*SPEED.
  - If the result is < 0, clamp x to 0 (y to 0) and negate that axis direction.
  - If the result is > X_MAX (Y_MAX), clamp to the limit and negate that axis direction.
  - Compute in 12-bit signed internally; never wrap.
  - Animation counter wraps at ANIM_DIV-1; on wrap, sprite_id steps 0->1->2->0.
  - Sprite facing: sprite_id+4 is not used; facing is not encoded.
  - Fly counter increments each tick.
  - hit flag set -> HIT with sprite_id=3.
  - Otherwise fly counter == FLY_FRAMES-1 -> ESCAPE.
  - If hit and timeout occur on the same tick, hit wins.
- HIT: position frozen; after HIT_FRAMES ticks -> FALL with sprite_id=4.
- FALL:
  - y += FALL_SPEED per tick; x is frozen.
  - When y >= Y_MAX: clamp y to Y_MAX, pulse shot_done for one cycle, go to IDLE.
- ESCAPE:
  - y -= SPEED per tick; flap animation continues.
  - When y would go below 0: y=0, pulse escaped for one cycle, go to IDLE.
- active=1 in FLY, HIT, FALL and ESCAPE.
- Outputs are registered; they change in the cycle after frame_tick (1-cycle latency).
- start while not IDLE: ignored, flag cleared.
- Reset mid-operation: return immediately to the reset values; no shot_done or escaped pulse.

Optional Feature:
Macro DUCK_LFSR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances every clock.
  - On spawn: xpos = LFSR[8:0] clamped to X_MAX; dx = LFSR[9] ? +1 : -1.
- Not defined: spawn at START_X with dx=+1; no LFSR logic is present.

Test Plan:
- Reset then 3 vsync edges, no start -> state IDLE, active=0, xpos=100, ypos=351, sprite_id=0.
- start, then 12 frames -> ypos=351-24=327, xpos=124, sprite_id stepped 0->1->2 at frames 6 and 12.
- Spawn at x=505, fly right -> at x=511 clamps and dx becomes -1; next frame x=509.
- hit pulse mid-frame during FLY -> next tick sprite_id=3, position frozen 30 frames, then sprite_id=4 and y increases by 4 per frame; shot_done pulses exactly once at y=351, then active=0.
- No hit for 600 frames -> ESCAPE; escaped pulses once when y reaches 0.
- hit and the 600th frame on the same tick -> HIT, not ESCAPE.
- aresetn low during FALL -> outputs return to reset values immediately; no shot_done pulse.
